// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state enum, tone half-period and width helpers for the M-ary FSK modulator
package fsk_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int half_period(int base, int step, int sym);
    return base + sym * step;
  endfunction
  function automatic int bitsFor(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fsk_tone_gen.sv
// fsk_tone_gen: square-wave tone generator; in halfPeriod/symEnd/start/active, out tone
module fsk_tone_gen #(
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [HW-1:0] halfPeriod,
  input  logic          symEnd,
  input  logic          start,
  input  logic          active,
  output logic          tone
);
  logic [HW-1:0] halfCnt;
  logic          wrap;
  assign wrap = halfCnt == halfPeriod - HW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tone    <= 1'b0;
      halfCnt <= '0;
    end else if (start) begin
      tone    <= 1'b1;
      halfCnt <= '0;
    end else if (active) begin
      tone    <= tone ^ wrap;
      halfCnt <= (symEnd || wrap) ? '0 : halfCnt + HW'(1);
    end else begin
      tone    <= 1'b0;
      halfCnt <= '0;
    end
endmodule

// File: rtl/fsk_mod_mary.sv
// fsk_mod_mary: M-ary FSK modulator; in en/in_data/in_valid, out in_ready/tone/sym_out/busy/word_done
module fsk_mod_mary
  import fsk_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BPS        = 1,
  parameter int SYM_CYCLES = 16,
  parameter int HALF_BASE  = 4,
  parameter int HALF_STEP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tone,
  output logic [BPS-1:0]    sym_out,
  output logic              busy,
  output logic              word_done
);
  localparam int NSYM = DATA_W / BPS;
  localparam int HW   = bitsFor(HALF_BASE + ((1 << BPS) - 1) * HALF_STEP + 1);
  localparam int SW   = bitsFor(SYM_CYCLES);
  localparam int IW   = bitsFor(NSYM);
  if (DATA_W % BPS != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BPS");
  end
  if (SYM_CYCLES < 2) begin : g_bad_sym
    $error("SYM_CYCLES must be at least 2");
  end
  if (HALF_BASE < 1) begin : g_bad_half
    $error("HALF_BASE must be at least 1");
  end
  state_t            state, stateNext;
  logic [DATA_W-1:0] shreg;
  logic [SW-1:0]     symCnt;
  logic [IW-1:0]     idx;
  logic              symEnd, wordEnd, accept;
  logic [BPS-1:0]    curSym;
  logic [HW-1:0]     halfPeriod;
  assign symEnd     = state == SEND && symCnt == SW'(SYM_CYCLES - 1);
  assign wordEnd    = symEnd && idx == IW'(NSYM - 1);
  assign in_ready   = en && (state == IDLE || wordEnd);
  assign accept     = in_valid && in_ready;
  assign curSym     = shreg[DATA_W-1 -: BPS];
  assign sym_out    = state == SEND ? curSym : '0;
  assign busy       = state == SEND;
  assign halfPeriod = HW'(half_period(HALF_BASE, HALF_STEP, int'(curSym)));
  always_comb stateNext = accept ? SEND : wordEnd ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg     <= '0;
      symCnt    <= '0;
      idx       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= wordEnd;
      if (accept) begin
        shreg  <= in_data;
        symCnt <= '0;
        idx    <= '0;
      end else if (state == SEND) begin
        symCnt <= symEnd ? '0 : symCnt + SW'(1);
        if (symEnd) begin
          shreg <= shreg << BPS;
          idx   <= wordEnd ? '0 : idx + IW'(1);
        end
      end
    end
  fsk_tone_gen #(.HW(HW)) u_tone (
    .clk       (clk),
    .rst       (rst),
    .halfPeriod(halfPeriod),
    .symEnd    (symEnd),
    .start     (accept && state == IDLE),
    .active    (stateNext == SEND),
    .tone      (tone)
  );
endmodule

// File: tb/tb_fsk_mod_mary.sv
// tb_fsk_mod_mary: three-configuration self-checking bench with a cycle-level behavioural model
module tb_fsk_mod_mary;
  localparam int DW[3] = '{4, 4, 8};
  localparam int BP[3] = '{1, 1, 2};
  localparam int SC[3] = '{16, 12, 16};
  localparam int HB = 4;
  localparam int HS = 2;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, inValid = 1'b0;
  logic [7:0] inData[3];
  logic rdy[3], tone[3], busy[3], done[3];
  logic [1:0] sym[3];
  logic s0, s1;
  logic [1:0] s2;
  int cyc = 0, nCmp = 0, nBad = 0;
  int pos[3] = '{-1, -1, -1};
  int word[3], run[3];
  logic eTone[3], eBusy[3], eDone[3];
  logic [1:0] eSym[3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sym[0] = {1'b0, s0};
  assign sym[1] = {1'b0, s1};
  assign sym[2] = s2;
  fsk_mod_mary d0 (.clk(clk), .rst(rst), .en(en), .in_data(inData[0][3:0]), .in_valid(inValid),
    .in_ready(rdy[0]), .tone(tone[0]), .sym_out(s0), .busy(busy[0]), .word_done(done[0]));
  fsk_mod_mary #(.SYM_CYCLES(12)) d1 (.clk(clk), .rst(rst), .en(en), .in_data(inData[1][3:0]),
    .in_valid(inValid), .in_ready(rdy[1]), .tone(tone[1]), .sym_out(s1), .busy(busy[1]), .word_done(done[1]));
  fsk_mod_mary #(.DATA_W(8), .BPS(2)) d2 (.clk(clk), .rst(rst), .en(en), .in_data(inData[2]),
    .in_valid(inValid), .in_ready(rdy[2]), .tone(tone[2]), .sym_out(s2), .busy(busy[2]), .word_done(done[2]));
  function automatic int wlen(int i);
    return DW[i] / BP[i] * SC[i];
  endfunction
  function automatic int symAt(int i, int w, int p);
    return (w >> (DW[i] - BP[i] * (p / SC[i] + 1))) & ((1 << BP[i]) - 1);
  endfunction
  always @(posedge clk or posedge rst) begin
    int np;
    bit acc, wasBusy, wrap;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pos[i] = -1; eTone[i] = 0; eSym[i] = 0; eBusy[i] = 0; eDone[i] = 0; run[i] = 0;
      end else begin
        acc = inValid && en && (pos[i] < 0 || pos[i] == wlen(i) - 1);
        wasBusy = pos[i] >= 0;
        eDone[i] = pos[i] == wlen(i) - 1;
        if (acc) begin
          np = 0;
          word[i] = int'(inData[i]) & ((1 << DW[i]) - 1);
        end else np = (pos[i] >= 0 && pos[i] < wlen(i) - 1) ? pos[i] + 1 : -1;
        if (np < 0) begin
          eTone[i] = 0; run[i] = 0; eSym[i] = 0; eBusy[i] = 0;
        end else begin
          if (!wasBusy) begin
            eTone[i] = 1; run[i] = 0;
          end else begin
            wrap = run[i] == HB + int'(eSym[i]) * HS - 1;
            if (wrap) eTone[i] = ~eTone[i];
            run[i] = (np % SC[i] == 0 || wrap) ? 0 : run[i] + 1;
          end
          eSym[i] = 2'(symAt(i, word[i], np));
          eBusy[i] = 1;
        end
        pos[i] = np;
      end
    end
  end
  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("d%0d.tone", i), tone[i], eTone[i]);
        chk($sformatf("d%0d.sym", i), sym[i], eSym[i]);
        chk($sformatf("d%0d.busy", i), busy[i], eBusy[i]);
        chk($sformatf("d%0d.done", i), done[i], eDone[i]);
        chk($sformatf("d%0d.ready", i), rdy[i], en && (pos[i] < 0 || pos[i] == wlen(i) - 1));
      end
    end
  end
  task automatic at(int n);
    if (n < cyc) begin
      nBad++;
      $display("FAIL sched: cycle %0d requested at cycle %0d", n, cyc);
    end
    while (cyc < n) @(negedge clk);
    #1;
  endtask
  initial begin
    int t;
    inData = '{8'h0, 8'h0, 8'h0};
    at(3);
    chk("rst.tone", tone[0], 0); chk("rst.busy", busy[0], 0); chk("rst.sym", sym[2], 0);
    rst = 0; en = 1;
    t = 10;
    at(t); inValid = 1; inData = '{8'h9, 8'h9, 8'hE4};
    at(t + 1); inValid = 0;
    chk("b.tone1", tone[0], 1); chk("b.busy1", busy[0], 1); chk("b.sym1", sym[0], 1); chk("q.sym1", sym[2], 3);
    at(t + 6); chk("b.tone6", tone[0], 1);
    at(t + 7); chk("b.tone7", tone[0], 0);
    at(t + 10); chk("q.tone10", tone[2], 1);
    at(t + 11); chk("q.tone11", tone[2], 0);
    at(t + 12); chk("b.tone12", tone[0], 0); chk("c.tone12", tone[1], 0);
    at(t + 13); chk("b.tone13", tone[0], 1); chk("c.tone13", tone[1], 1); chk("c.sym13", sym[1], 0);
    at(t + 16); chk("b.tone16", tone[0], 1); chk("c.tone16", tone[1], 1);
    at(t + 17); chk("b.tone17", tone[0], 1); chk("b.sym17", sym[0], 0); chk("c.tone17", tone[1], 0); chk("q.sym17", sym[2], 2);
    at(t + 20); chk("b.tone20", tone[0], 1);
    at(t + 21); chk("b.tone21", tone[0], 0);
    at(t + 33); chk("q.sym33", sym[2], 1);
    at(t + 49); chk("q.sym49", sym[2], 0);
    at(t + 64); chk("b.busy64", busy[0], 1); chk("b.done64", done[0], 0);
    at(t + 65); chk("b.done65", done[0], 1); chk("b.tone65", tone[0], 0); chk("b.busy65", busy[0], 0); chk("q.done65", done[2], 1);
    at(t + 66); chk("b.done66", done[0], 0);
    t = 80;
    at(t); inValid = 1; inData = '{8'h9, 8'h9, 8'hE4};
    at(t + 1); inData = '{8'h6, 8'h6, 8'h1B};
    at(t + 64); chk("bb.ready64", rdy[0], 1);
    at(t + 65); inValid = 0;
    chk("bb.sym65", sym[0], 0); chk("bb.busy65", busy[0], 1); chk("bb.done65", done[0], 1);
    at(t + 128); chk("bb.busy128", busy[0], 1);
    at(t + 129); chk("bb.done129", done[0], 1); chk("bb.busy129", busy[0], 0);
    at(220); en = 0; inValid = 1; inData = '{8'h5, 8'h5, 8'h5A};
    at(225); chk("en.ready", rdy[0], 0); chk("en.busy", busy[0], 0);
    t = 230;
    at(t); en = 1;
    at(t + 10); en = 0;
    chk("en.busy10", busy[0], 1);
    at(t + 65); chk("en.done65", done[0], 1);
    at(t + 66); chk("en.busy66", busy[0], 0); chk("en.ready66", rdy[0], 0);
    at(300); inValid = 0; en = 1;
    t = 310;
    at(t); inValid = 1; inData = '{8'hA, 8'hA, 8'hC3};
    at(t + 1); inValid = 0;
    at(t + 20); rst = 1;
    #1;
    chk("ar.tone", tone[0], 0); chk("ar.busy", busy[0], 0); chk("ar.sym", sym[2], 0); chk("ar.busy2", busy[2], 0);
    at(t + 22); rst = 0;
    #1;
    chk("ar.ready", rdy[0], 1);
    at(t + 23); chk("ar.done", done[0], 0);
    for (int c = 340; c < 3340; c++) begin
      at(c);
      rst = $urandom_range(0, 499) == 0;
      en = $urandom_range(0, 9) != 0;
      inValid = $urandom_range(0, 3) != 0;
      inData = '{8'($urandom), 8'($urandom), 8'($urandom)};
    end
    at(3345);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
